control_sequencer: RTL and testbench

Hardwired control unit that drives the DataPath's control inputs for ALU-class instructions. Each instruction runs as a fetch (T0–T2) followed by a class-dependent execute sequence (T3–T6), so the datapath runs without hand-sequenced stimulus. The block sits beside DataPath. It reads the IR contents and drives every out/in strobe. Register selection goes through Gra/Grb/Grc to the select-and-encode logic.

---
 rtl/control_pkg.sv | 91 +++++++++
 rtl/control_sequencer_if.sv | 48 ++++
 rtl/control_op_decode.sv | 22 ++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, state and op-class enumerations and the internal control word.
package control_pkg;

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpRor  = 5'b00111;
    localparam logic [4:0] OpRol  = 5'b01000;
    localparam logic [4:0] OpShr  = 5'b01001;
    localparam logic [4:0] OpShra = 5'b01010;
    localparam logic [4:0] OpShl  = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 27;
    localparam int unsigned RaMsb     = 26;
    localparam int unsigned RaLsb     = 23;
    localparam int unsigned RbMsb     = 22;
    localparam int unsigned RbLsb     = 19;
    localparam int unsigned RcMsb     = 18;
    localparam int unsigned RcLsb     = 15;

    typedef enum logic [3:0] {
        StReset = 4'd0,
        StT0    = 4'd1,
        StT1    = 4'd2,
        StT2    = 4'd3,
        StT3    = 4'd4,
        StT4    = 4'd5,
        StT5    = 4'd6,
        StT6    = 4'd7,
        StHalt  = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu3    = 3'd0,
        ClsAlu2    = 3'd1,
        ClsMulDiv  = 3'd2,
        ClsNop     = 3'd3,
        ClsHalt    = 3'd4,
        ClsIllegal = 3'd5
    } op_class_e;

    typedef struct packed {
        logic pc_out;
        logic mdr_out;
        logic zlow_out;
        logic zhigh_out;
        logic r_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic r_in;
        logic zlow_in;
        logic zhigh_in;
        logic hi_in;
        logic lo_in;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic alu_en;
    } ctrl_word_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[OpcodeMsb:OpcodeLsb];
    endfunction

    function automatic logic [3:0] ir_ra(input logic [31:0] ir);
        return ir[RaMsb:RaLsb];
    endfunction

    function automatic logic [3:0] ir_rb(input logic [31:0] ir);
        return ir[RbMsb:RbLsb];
    endfunction

    function automatic logic [3:0] ir_rc(input logic [31:0] ir);
        return ir[RcMsb:RcLsb];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the DataPath (slave):
// IR and Stop flow in, every strobe, ALUop and status flow out.
interface control_sequencer_if;

    logic [31:0] IR;
    logic        Stop;

    logic        PCout;
    logic        MDRout;
    logic        Zlowout;
    logic        ZHighout;
    logic        Rout;

    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Rin;
    logic        ZLowIn;
    logic        ZHighIn;
    logic        HIin;
    logic        LOin;

    logic        Read;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic [4:0]  ALUop;
    logic        Run;
    logic        Illegal;

    modport master (
        input  IR, Stop,
        output PCout, MDRout, Zlowout, ZHighout, Rout,
        output PCin, IncPC, MARin, MDRin, IRin, Yin, Rin, ZLowIn, ZHighIn, HIin, LOin,
        output Read, Gra, Grb, Grc, ALUop, Run, Illegal
    );

    modport slave (
        output IR, Stop,
        input  PCout, MDRout, Zlowout, ZHighout, Rout,
        input  PCin, IncPC, MARin, MDRin, IRin, Yin, Rin, ZLowIn, ZHighIn, HIin, LOin,
        input  Read, Gra, Grb, Grc, ALUop, Run, Illegal
    );

endinterface

// File: rtl/control_op_decode.sv
// Pure combinational opcode to instruction-class mapping.
module control_op_decode
    import control_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  op_class_o
);

    always_comb begin
        op_class_o = ClsIllegal;
        case (opcode_i)
            OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl:
                op_class_o = ClsAlu3;
            OpNeg, OpNot: op_class_o = ClsAlu2;
            OpMul, OpDiv: op_class_o = ClsMulDiv;
            OpNop:        op_class_o = ClsNop;
            OpHalt:       op_class_o = ClsHalt;
            default:      op_class_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: state register, next-state logic and a
// per-state control word that drives the DataPath strobes.
module control_sequencer
    import control_pkg::*;
(
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master ctrl
);

    state_e     state_q, state_d;
    logic       illegal_q;
    op_class_e  op_class;
    ctrl_word_t cw;

    control_op_decode u_op_decode (
        .opcode_i   (ir_opcode(ctrl.IR)),
        .op_class_o (op_class)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q   <= StReset;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Illegal shows up in the cycle after T2, i.e. the next fetch's T0.
            illegal_q <= (state_q == StT2) && (op_class == ClsIllegal);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = ctrl.Stop ? StHalt : StT1;
            StT1:    state_d = StT2;
            StT2: begin
                case (op_class)
                    ClsAlu3, ClsAlu2, ClsMulDiv: state_d = StT3;
                    ClsHalt:                     state_d = StHalt;
                    default:                     state_d = StT0;
                endcase
            end
            StT3:    state_d = StT4;
            StT4:    state_d = (op_class == ClsAlu2) ? StT0 : StT5;
            StT5:    state_d = (op_class == ClsMulDiv) ? StT6 : StT0;
            StT6:    state_d = StT0;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        cw = '0;
        case (state_q)
            StT0: begin
                // A halt request suppresses the whole fetch word.
                if (!ctrl.Stop) begin
                    cw.pc_out = 1'b1;
                    cw.mar_in = 1'b1;
                    cw.inc_pc = 1'b1;
                    cw.pc_in  = 1'b1;
                end
            end
            StT1: begin
                cw.read   = 1'b1;
                cw.mdr_in = 1'b1;
            end
            StT2: begin
                cw.mdr_out = 1'b1;
                cw.ir_in   = 1'b1;
            end
            StT3: begin
                case (op_class)
                    ClsAlu3: begin
                        cw.grb   = 1'b1;
                        cw.r_out = 1'b1;
                        cw.y_in  = 1'b1;
                    end
                    ClsAlu2: begin
                        cw.grb      = 1'b1;
                        cw.r_out    = 1'b1;
                        cw.alu_en   = 1'b1;
                        cw.zlow_in  = 1'b1;
                        cw.zhigh_in = 1'b1;
                    end
                    ClsMulDiv: begin
                        cw.gra   = 1'b1;
                        cw.r_out = 1'b1;
                        cw.y_in  = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (op_class)
                    ClsAlu3: begin
                        cw.grc      = 1'b1;
                        cw.r_out    = 1'b1;
                        cw.alu_en   = 1'b1;
                        cw.zlow_in  = 1'b1;
                        cw.zhigh_in = 1'b1;
                    end
                    ClsAlu2: begin
                        cw.zlow_out = 1'b1;
                        cw.gra      = 1'b1;
                        cw.r_in     = 1'b1;
                    end
                    ClsMulDiv: begin
                        cw.grb      = 1'b1;
                        cw.r_out    = 1'b1;
                        cw.alu_en   = 1'b1;
                        cw.zlow_in  = 1'b1;
                        cw.zhigh_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                case (op_class)
                    ClsAlu3: begin
                        cw.zlow_out = 1'b1;
                        cw.gra      = 1'b1;
                        cw.r_in     = 1'b1;
                    end
                    ClsMulDiv: begin
                        cw.zlow_out = 1'b1;
                        cw.lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                if (op_class == ClsMulDiv) begin
                    cw.zhigh_out = 1'b1;
                    cw.hi_in     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ctrl.PCout    = cw.pc_out;
    assign ctrl.MDRout   = cw.mdr_out;
    assign ctrl.Zlowout  = cw.zlow_out;
    assign ctrl.ZHighout = cw.zhigh_out;
    assign ctrl.Rout     = cw.r_out;
    assign ctrl.PCin     = cw.pc_in;
    assign ctrl.IncPC    = cw.inc_pc;
    assign ctrl.MARin    = cw.mar_in;
    assign ctrl.MDRin    = cw.mdr_in;
    assign ctrl.IRin     = cw.ir_in;
    assign ctrl.Yin      = cw.y_in;
    assign ctrl.Rin      = cw.r_in;
    assign ctrl.ZLowIn   = cw.zlow_in;
    assign ctrl.ZHighIn  = cw.zhigh_in;
    assign ctrl.HIin     = cw.hi_in;
    assign ctrl.LOin     = cw.lo_in;
    assign ctrl.Read     = cw.read;
    assign ctrl.Gra      = cw.gra;
    assign ctrl.Grb      = cw.grb;
    assign ctrl.Grc      = cw.grc;
    assign ctrl.ALUop    = cw.alu_en ? ir_opcode(ctrl.IR) : 5'd0;
    assign ctrl.Run      = (state_q != StReset) && (state_q != StHalt);
    assign ctrl.Illegal  = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Random instruction stream against a per-class control-word table model.
module tb_control_sequencer;

    localparam logic [26:0] WIllegal  = 27'd1 << 5;
    localparam logic [26:0] WRun      = 27'd1 << 6;
    localparam logic [26:0] WGrc      = 27'd1 << 7;
    localparam logic [26:0] WGrb      = 27'd1 << 8;
    localparam logic [26:0] WGra      = 27'd1 << 9;
    localparam logic [26:0] WRead     = 27'd1 << 10;
    localparam logic [26:0] WLoIn     = 27'd1 << 11;
    localparam logic [26:0] WHiIn     = 27'd1 << 12;
    localparam logic [26:0] WZHighIn  = 27'd1 << 13;
    localparam logic [26:0] WZLowIn   = 27'd1 << 14;
    localparam logic [26:0] WRin      = 27'd1 << 15;
    localparam logic [26:0] WYin      = 27'd1 << 16;
    localparam logic [26:0] WIrIn     = 27'd1 << 17;
    localparam logic [26:0] WMdrIn    = 27'd1 << 18;
    localparam logic [26:0] WMarIn    = 27'd1 << 19;
    localparam logic [26:0] WIncPc    = 27'd1 << 20;
    localparam logic [26:0] WPcIn     = 27'd1 << 21;
    localparam logic [26:0] WRout     = 27'd1 << 22;
    localparam logic [26:0] WZHighOut = 27'd1 << 23;
    localparam logic [26:0] WZLowOut  = 27'd1 << 24;
    localparam logic [26:0] WMdrOut   = 27'd1 << 25;
    localparam logic [26:0] WPcOut    = 27'd1 << 26;

    localparam int KAlu3 = 0, KAlu2 = 1, KMulDiv = 2, KNop = 3, KHalt = 4, KIllegal = 5;

    logic Clock = 1'b0;
    logic Clear;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic illegal_pending = 1'b0;
    logic [26:0] exp_q[$];

    control_sequencer_if bus ();

    control_sequencer u_dut (
        .Clock (Clock),
        .Clear (Clear),
        .ctrl  (bus)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [26:0] observe();
        return {bus.PCout, bus.MDRout, bus.Zlowout, bus.ZHighout, bus.Rout,
                bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Rin,
                bus.ZLowIn, bus.ZHighIn, bus.HIin, bus.LOin, bus.Read,
                bus.Gra, bus.Grb, bus.Grc, bus.Run, bus.Illegal, bus.ALUop};
    endfunction

    function automatic int class_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return KAlu3;
        if (op == 5'd17 || op == 5'd18) return KAlu2;
        if (op == 5'd15 || op == 5'd16) return KMulDiv;
        if (op == 5'd26) return KNop;
        if (op == 5'd27) return KHalt;
        return KIllegal;
    endfunction

    // One cycle: sample mid-cycle, then advance past the next rising edge.
    task automatic step(input logic [26:0] exp, input string tag);
        logic [26:0] w;
        logic        one_bus;
        @(negedge Clock);
        w = observe();
        one_bus = ($countones(w[26:22]) <= 1);
        check_eq(tag, {5'd0, w}, {5'd0, exp});
        check_eq("one_bus_driver", {31'd0, one_bus}, 32'd1);
        @(posedge Clock);
        #1;
    endtask

    function automatic int build_seq(input logic [31:0] ir);
        logic [26:0] alu;
        int          cls;
        alu = {22'd0, ir[31:27]};
        cls = class_of(ir[31:27]);
        exp_q.delete();
        exp_q.push_back(WRun | WPcOut | WMarIn | WIncPc | WPcIn);
        exp_q.push_back(WRun | WRead | WMdrIn);
        exp_q.push_back(WRun | WMdrOut | WIrIn);
        case (cls)
            KAlu3: begin
                exp_q.push_back(WRun | WGrb | WRout | WYin);
                exp_q.push_back(WRun | WGrc | WRout | alu | WZLowIn | WZHighIn);
                exp_q.push_back(WRun | WZLowOut | WGra | WRin);
            end
            KAlu2: begin
                exp_q.push_back(WRun | WGrb | WRout | alu | WZLowIn | WZHighIn);
                exp_q.push_back(WRun | WZLowOut | WGra | WRin);
            end
            KMulDiv: begin
                exp_q.push_back(WRun | WGra | WRout | WYin);
                exp_q.push_back(WRun | WGrb | WRout | alu | WZLowIn | WZHighIn);
                exp_q.push_back(WRun | WZLowOut | WLoIn);
                exp_q.push_back(WRun | WZHighOut | WHiIn);
            end
            default: ;
        endcase
        return cls;
    endfunction

    task automatic halt_and_clear();
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) step('0, "halted");
        Clear = 1'b1;
        step('0, "halt_clear");
        n = $urandom_range(0, 1);
        for (int i = 0; i < n; i++) step('0, "reset_held");
        Clear = 1'b0;
        step('0, "reset_release");
    endtask

    // Entered and left just after the edge that starts a T0 cycle.
    task automatic run_instr(input logic [31:0] ir, input logic stop, input int abort_at);
        int          cls;
        logic [26:0] pend;
        pend = illegal_pending ? WIllegal : '0;
        illegal_pending = 1'b0;
        bus.IR   = ir;
        bus.Stop = stop;
        if (stop) begin
            step(WRun | pend, "t0_stop");
            bus.Stop = 1'b0;
            halt_and_clear();
            return;
        end
        cls = build_seq(ir);
        exp_q[0] = exp_q[0] | pend;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) Clear = 1'b1;
            step(exp_q[i], $sformatf("op%05b_t%0d", ir[31:27], i));
            if (i == abort_at) begin
                Clear = 1'b0;
                step('0, "reset_after_abort");
                return;
            end
        end
        if (cls == KIllegal) illegal_pending = 1'b1;
        if (cls == KHalt) halt_and_clear();
    endtask

    initial begin
        logic [31:0] ir;
        logic [4:0]  op;
        logic [26:0] pend;
        Clear    = 1'b1;
        bus.IR   = 32'h0;
        bus.Stop = 1'b0;
        @(posedge Clock);
        #1;
        step('0, "reset_state");
        Clear = 1'b0;
        step('0, "reset_release");

        run_instr(32'h28918000, 1'b0, -1);
        run_instr(32'h93180000, 1'b0, -1);
        run_instr(32'h7A280000, 1'b0, -1);
        run_instr(32'hF8000000, 1'b0, -1);
        run_instr(32'hD8000000, 1'b0, -1);
        run_instr(32'h18918000, 1'b1, -1);
        run_instr(32'h18918000, 1'b0, 4);

        // Clear and Stop together in T0: Stop masks the fetch word, Clear wins.
        pend = illegal_pending ? WIllegal : '0;
        illegal_pending = 1'b0;
        bus.Stop = 1'b1;
        Clear    = 1'b1;
        step(WRun | pend, "t0_clear_stop");
        bus.Stop = 1'b0;
        Clear    = 1'b0;
        step('0, "reset_after_clear_stop");
        run_instr(32'h3A280000, 1'b0, -1);

        for (int k = 0; k < 300; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27 && $urandom_range(0, 3) != 0) op = 5'd3;
            ir = {op, 27'($urandom())};
            run_instr(ir, ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
